// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operands and opcode in, registered result and status out.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             ovfl;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input r, zero, ovfl, busy, done);
  modport slave  (input start, op, a, b, output r, zero, ovfl, busy, done);
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/add/sub/slt finish in 1 cycle, shifts step 1 bit/cycle, MUL is WIDTH-cycle shift-add.
// Latency 1 (ALU), max(n,1)+1 (shift), WIDTH+1 (MUL); start is ignored while busy, accepted in IDLE or FIN.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input logic   clk,
  input logic   reset,
  alu_mc_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_NOR = 4'd2, OP_ADD = 4'd3,
                         OP_SUB = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_SRA = 4'd8, OP_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   r_q;
  logic               zero_q, ovfl_q, busy_q, done_q;

  logic [WIDTH-1:0]   sum, diff, alu_r, sh_next;
  logic [2*WIDTH-1:0] mul_next;
  logic               alu_v, is_seq;

  assign sum      = bus.a + bus.b;
  assign diff     = bus.a - bus.b;
  assign is_seq   = (bus.op >= OP_SLL) && (bus.op <= OP_MUL);
  assign mul_next = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (bus.op)
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_NOR: alu_r = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_r = sum;
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff;
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    sh_next = acc;
    case (op_q)
      OP_SLL: sh_next = acc << 1;
      OP_SRL: sh_next = acc >> 1;
      OP_SRA: sh_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: sh_next = acc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      r_q    <= '0;
      zero_q <= 1'b1;
      ovfl_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (bus.start) begin
            op_q <= bus.op;
            if (is_seq) begin
              state  <= RUN;
              busy_q <= 1'b1;
              acc    <= bus.a;
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              cnt    <= (bus.op == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, bus.b[SHW-1:0]};
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
              r_q    <= alu_r;
              zero_q <= (alu_r == '0);
              ovfl_q <= alu_v;
            end
          end
        end
        RUN: begin
          // Result registers stay frozen until the final step so partial values never leak out.
          if (op_q == OP_MUL) begin
            prod   <= mul_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == (SHW+1)'(1)) begin
              state  <= FIN;
              done_q <= 1'b1;
              r_q    <= mul_next[WIDTH-1:0];
              zero_q <= (mul_next[WIDTH-1:0] == '0);
              ovfl_q <= |mul_next[2*WIDTH-1:WIDTH];
            end else begin
              cnt    <= cnt - (SHW+1)'(1);
              busy_q <= 1'b1;
            end
          end else if (cnt == '0) begin
            state  <= FIN;
            done_q <= 1'b1;
            r_q    <= acc;
            zero_q <= (acc == '0);
            ovfl_q <= 1'b0;
          end else begin
            acc <= sh_next;
            if (cnt == (SHW+1)'(1)) begin
              state  <= FIN;
              done_q <= 1'b1;
              r_q    <= sh_next;
              zero_q <= (sh_next == '0);
              ovfl_q <= 1'b0;
            end else begin
              cnt    <= cnt - (SHW+1)'(1);
              busy_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r    = r_q;
  assign bus.zero = zero_q;
  assign bus.ovfl = ovfl_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
